// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// Holds the receive FSM states, register offsets and status bit positions.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_e;

    localparam logic [31:0] PS2_REG_DATA   = 32'h0;
    localparam logic [31:0] PS2_REG_STATUS = 32'h4;

    localparam int unsigned ST_EMPTY   = 0;
    localparam int unsigned ST_FULL    = 1;
    localparam int unsigned ST_FERR    = 2;
    localparam int unsigned ST_OVF     = 3;
    localparam int unsigned ST_CNT_LSB = 4;

endpackage

// File: rtl/ps2_fifo.sv
// Scan-code FIFO: power-of-two depth, first-word fall-through read port.
// A pop in the same cycle frees a slot, so a push into a full FIFO succeeds.
module ps2_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push;
    logic          do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign count   = cnt_q;
    assign dout    = mem[rd_q];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) wr_d = wr_q + 1'b1;
        if (do_pop)  rd_d = rd_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_q] <= din;
    end

endmodule

// File: rtl/ps2_rx_io.sv
// Memory-mapped PS/2 receiver: sync, frame FSM, FIFO and bus registers.
// Define PS2_RX_TIMEOUT_EN to abort stalled partial frames.
module ps2_rx_io
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rEn,
    input  logic [31:0] addr,
    output logic [31:0] dataOut,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic        irq
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [2:0]  csync_q;
    logic [1:0]  dsync_q;
    logic        fall;
    logic        bit_in;
    ps2_state_e  state_q, state_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        pok_q, pok_d;
    logic        ferr_q, ferr_d;
    logic        ovf_q, ovf_d;
    logic [31:0] dout_q, dout_d;
    logic        push_req;
    logic        ferr_set;
    logic        rd_data;
    logic        rd_stat;
    logic        pop;
    logic [7:0]  f_dout;
    logic [AW:0] f_count;
    logic        f_full;
    logic        f_empty;
    logic [31:0] status;
    logic        unused_ok;

    // Idle bus level is high, so the flops reset to 1 to avoid a fake edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            csync_q <= 3'b111;
            dsync_q <= 2'b11;
        end else begin
            csync_q <= {csync_q[1:0], ps2_clk};
            dsync_q <= {dsync_q[0], ps2_data};
        end
    end

    assign fall   = csync_q[2] & ~csync_q[1];
    assign bit_in = dsync_q[1];

`ifdef PS2_RX_TIMEOUT_EN
    logic [31:0] tmo_q, tmo_d;
    logic        tmo_hit;

    assign tmo_hit = (state_q != IDLE) && !fall &&
                     (tmo_q == 32'(TIMEOUT_CYCLES));

    always_comb begin
        tmo_d = tmo_q + 32'd1;
        if (state_q == IDLE || fall || tmo_hit) tmo_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) tmo_q <= '0;
        else       tmo_q <= tmo_d;
    end
`else
    logic tmo_hit;
    logic unused_tmo;
    assign tmo_hit    = 1'b0;
    assign unused_tmo = (TIMEOUT_CYCLES == 0);
`endif

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        pok_d    = pok_q;
        push_req = 1'b0;
        ferr_set = 1'b0;
        if (tmo_hit) begin
            state_d  = IDLE;
            ferr_set = 1'b1;
        end else if (fall) begin
            unique case (state_q)
                IDLE: begin
                    if (!bit_in) begin
                        state_d  = DATA;
                        bitcnt_d = '0;
                    end
                end
                DATA: begin
                    shreg_d  = {bit_in, shreg_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    pok_d   = ^{shreg_q, bit_in};
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (bit_in && pok_q) push_req = 1'b1;
                    else                 ferr_set = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign rd_data = rEn && (addr[2] == PS2_REG_DATA[2]);
    assign rd_stat = rEn && (addr[2] == PS2_REG_STATUS[2]);
    assign pop     = rd_data && !f_empty;

    ps2_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .pop   (pop),
        .din   (shreg_q),
        .dout  (f_dout),
        .count (f_count),
        .full  (f_full),
        .empty (f_empty)
    );

    always_comb begin
        status                      = '0;
        status[ST_EMPTY]            = f_empty;
        status[ST_FULL]             = f_full;
        status[ST_FERR]             = ferr_q;
        status[ST_OVF]              = ovf_q;
        status[ST_CNT_LSB +: 4]     = 4'(f_count);
    end

    // A new error in the clearing cycle wins over the clear.
    always_comb begin
        ferr_d = (ferr_q & ~rd_stat) | ferr_set;
        ovf_d  = (ovf_q & ~rd_stat) | (push_req & f_full & ~pop);
        dout_d = dout_q;
        if (rd_data) dout_d = f_empty ? 32'h0 : {23'b0, 1'b1, f_dout};
        if (rd_stat) dout_d = status;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            bitcnt_q <= '0;
            shreg_q  <= '0;
            pok_q    <= 1'b0;
            ferr_q   <= 1'b0;
            ovf_q    <= 1'b0;
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            pok_q    <= pok_d;
            ferr_q   <= ferr_d;
            ovf_q    <= ovf_d;
            dout_q   <= dout_d;
        end
    end

    assign dataOut   = dout_q;
    assign irq       = ~f_empty;
    assign unused_ok = ^{addr[31:3], addr[1:0]};

endmodule

// File: tb/tb_ps2_rx_io.sv
// Directed bench for ps2_rx_io: vector table plus multi-cycle sequences.
// Covers the timeout path when PS2_RX_TIMEOUT_EN is defined.
module tb_ps2_rx_io;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rEn = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] dataOut;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;

    ps2_rx_io #(
        .FIFO_DEPTH     (8),
        .TIMEOUT_CYCLES (200)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rEn      (rEn),
        .addr     (addr),
        .dataOut  (dataOut),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          send;
        logic [7:0]  b;
        bit          pflip;
        bit          stopb;
        bit          exp_irq;
        logic [31:0] ra;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [9];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // rd=1 pulses a data read in the cycle the FSM samples this bit.
    task automatic ps2_bit(input logic b, input bit rd);
        @(negedge clk);
        ps2_data = b;
        repeat (4) @(negedge clk);
        ps2_clk = 1'b0;
        if (rd) begin
            repeat (2) @(negedge clk);
            rEn  = 1'b1;
            addr = 32'h0;
            @(negedge clk);
            rEn  = 1'b0;
            repeat (2) @(negedge clk);
        end else begin
            repeat (5) @(negedge clk);
        end
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit pflip,
                              input bit stopb, input bit rd);
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], 1'b0);
        ps2_bit(~(^b) ^ pflip, 1'b0);
        ps2_bit(stopb, rd);
        repeat (5) @(negedge clk);
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        rEn  = 1'b1;
        addr = a;
        @(negedge clk);
        rEn  = 1'b0;
        d    = dataOut;
    endtask

    logic [31:0] rd;

    initial begin
        tbl[0] = '{1, 8'h1C, 0, 1, 1, 32'h0, 32'h0000011C};
        tbl[1] = '{0, 8'h00, 0, 1, 0, 32'h0, 32'h00000000};
        tbl[2] = '{1, 8'h1C, 1, 1, 0, 32'h4, 32'h00000005};
        tbl[3] = '{0, 8'h00, 0, 1, 0, 32'h4, 32'h00000001};
        tbl[4] = '{1, 8'hA5, 0, 0, 0, 32'h4, 32'h00000005};
        tbl[5] = '{1, 8'hFF, 0, 1, 1, 32'h4, 32'h00000010};
        tbl[6] = '{0, 8'h00, 0, 1, 1, 32'h0, 32'h000001FF};
        tbl[7] = '{1, 8'h00, 0, 1, 1, 32'h0, 32'h00000100};
        tbl[8] = '{0, 8'h00, 0, 1, 0, 32'h4, 32'h00000001};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_dataOut", dataOut, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        bus_read(32'h4, rd);
        check("reset_status", rd, 32'h1);

        for (int i = 0; i < 9; i++) begin
            if (tbl[i].send)
                send_frame(tbl[i].b, tbl[i].pflip, tbl[i].stopb, 1'b0);
            check($sformatf("vec%0d_irq", i), {31'b0, irq},
                  {31'b0, tbl[i].exp_irq});
            bus_read(tbl[i].ra, rd);
            check($sformatf("vec%0d_read", i), rd, tbl[i].exp);
        end

        // Overflow: nine frames into an eight-deep FIFO.
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 1, 0);
        bus_read(32'h4, rd);
        check("ovf_status", rd, 32'h0000008A);
        for (int i = 1; i <= 8; i++) begin
            bus_read(32'h0, rd);
            check($sformatf("ovf_pop%0d", i), rd, 32'h100 + 32'(i));
        end
        bus_read(32'h0, rd);
        check("ovf_pop_empty", rd, 32'h0);
        bus_read(32'h4, rd);
        check("ovf_cleared", rd, 32'h1);

        // Same-cycle push and pop with a full FIFO.
        for (int i = 1; i <= 8; i++) send_frame(8'(i), 0, 1, 0);
        send_frame(8'h55, 0, 1, 1);
        check("pp_first_pop", dataOut, 32'h00000101);
        bus_read(32'h4, rd);
        check("pp_status", rd, 32'h00000082);
        for (int i = 2; i <= 8; i++) begin
            bus_read(32'h0, rd);
            check($sformatf("pp_pop%0d", i), rd, 32'h100 + 32'(i));
        end
        bus_read(32'h0, rd);
        check("pp_last_pop", rd, 32'h00000155);
        bus_read(32'h4, rd);
        check("pp_final_status", rd, 32'h1);

`ifdef PS2_RX_TIMEOUT_EN
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1, 1'b0);
        repeat (300) @(negedge clk);
        bus_read(32'h4, rd);
        check("tmo_status", rd, 32'h00000005);
        send_frame(8'hF0, 0, 1, 0);
        bus_read(32'h0, rd);
        check("tmo_recover", rd, 32'h000001F0);
`endif

        // Reset in the middle of a frame, with a byte already queued.
        send_frame(8'h33, 0, 1, 0);
        check("rst_pre_irq", {31'b0, irq}, 32'h1);
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_dataOut", dataOut, 32'h0);
        check("rst_mid_irq", {31'b0, irq}, 32'h0);
        send_frame(8'h2A, 0, 1, 0);
        bus_read(32'h0, rd);
        check("rst_mid_frame", rd, 32'h0000012A);
        bus_read(32'h0, rd);
        check("rst_mid_empty", rd, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ps2_rx_io.md
# ps2_rx_io

Memory-mapped PS/2 keyboard receiver: the input-direction counterpart to the VGA output peripheral on the processor's I/O bus. It deserialises 11-bit PS/2 frames from the keyboard's `ps2_clk`/`ps2_data` lines and checks start, parity and stop bits. Valid scan-code bytes are buffered in a small FIFO. The CPU pops bytes and reads sticky error status through load instructions on the same addr/data bus as the rest of the I/O space.

## Interface
- `FIFO_DEPTH`, 8: scan-code FIFO entries; power of two, at least 2.
- `TIMEOUT_CYCLES`, 100000: idle `clk` cycles (1 ms at 100 MHz) before a partial frame is aborted; used only with the timeout feature.
- `clk`  in  1: system clock, 100 MHz.
- `reset`  in  1: synchronous, active-high reset.
- `rEn`  in  1: bus read strobe, one cycle per access.
- `addr`  in  32: byte address; only `addr[2]` is decoded; base decode is external.
- `dataOut`  out  32: registered read data.
- `ps2_clk`  in  1: raw keyboard clock, asynchronous.
- `ps2_data`  in  1: raw keyboard data, asynchronous.
- `irq`  out  1: high while the FIFO is non-empty.

## Operation
- **Input synchronisation.** `ps2_clk` and `ps2_data` each pass through a 2-FF synchroniser. A third flop on the clock path feeds edge detection: a falling edge is synchronised-previous=1 and synchronised-current=0.
- **Receive FSM, IDLE.**
  - On a falling edge with data=0 (start bit), go to DATA with `bitcnt`=0.
  - On a falling edge with data=1, stay in IDLE (spurious edge ignored).
- **Receive FSM, DATA.** Each falling edge shifts data into `shreg` LSB-first. After the 8th bit, go to PARITY.
- **Receive FSM, PARITY.** Sample the parity bit. Parity is OK when the 8 data bits plus the parity bit contain an odd number of 1s. Go to STOP.
- **Receive FSM, STOP.** Sample the stop bit, then return to IDLE.
  - Stop=1 and parity OK: push `shreg` into the FIFO.
  - Otherwise: set sticky `frame_err` and discard the byte.
  - Push while the FIFO is full: drop the byte and set sticky `overflow`.
- **Data register, `addr[2]`=0.** On `rEn`, `dataOut` loads {23'b0, `valid`, `byte[7:0]`}.
  - `valid` = FIFO non-empty.
  - If non-empty, the head entry is popped.
  - If empty, `dataOut` loads 0 and no state changes.
- **Status register, `addr[2]`=1.** On `rEn`, `dataOut` loads {24'b0, `count[3:0]`, `overflow`, `frame_err`, `full`, `empty`}.
  - `count` is zero-extended or truncated to 4 bits.
  - The read clears `overflow` and `frame_err` in the same cycle.
  - If an error event occurs in the same cycle as the clearing read, the new error wins: the bit stays set.
- **Push and pop in the same cycle.** Both occur; `count` is unchanged. When full, the pop frees the slot first, so the push succeeds and `overflow` is not set.

## Timing
- **Reset values.** `dataOut`=0, `irq`=0, FSM=IDLE, `bitcnt`=0, `shreg`=0, FIFO empty (pointers=0), `overflow`=0, `frame_err`=0, synchroniser flops=1 (idle bus level).
- **Reset mid-frame.** The partial frame is discarded; reception resumes at the next start bit after reset deasserts.
- **Edge-detect latency.** A raw `ps2_clk` fall is detected 2–3 `clk` cycles after it occurs. The bit is registered on the next edge of `clk`.
- **FIFO visibility.** A byte is in the FIFO, and `irq`=1, one cycle after the stop bit is sampled.
- **Read latency.** `dataOut` is valid the cycle after the `rEn` cycle and holds until the next `rEn`. Back-to-back `rEn` cycles pop consecutive entries.
- **Bus rate.** No minimum PS/2 bit period is required beyond 4 `clk` cycles per half-period.

## Configuration
- **`PS2_RX_TIMEOUT_EN` defined.**
  - A counter runs in every state except IDLE and resets on each falling edge.
  - On reaching `TIMEOUT_CYCLES`, the FSM returns to IDLE and sets `frame_err`; no byte is pushed.
  - The counter is held at 0 in IDLE.
- **`PS2_RX_TIMEOUT_EN` not defined.** No counter is synthesised. A partial frame waits indefinitely for more edges, and `TIMEOUT_CYCLES` is ignored.

## Structure
- **Package `ps2_pkg`:**
  - FSM state enum (IDLE, DATA, PARITY, STOP);
  - register offsets `PS2_REG_DATA`=0 and `PS2_REG_STATUS`=4;
  - status bit-position constants.
- **Sub-module `ps2_fifo`:** a synchronous FIFO with parameter `DEPTH`, `push`/`pop`/`din`/`dout`/`count`/`full`/`empty`, and same-cycle push/pop support.
- **Top level:** the synchroniser, FSM and register/bus logic stay in `ps2_rx_io`.

## Test plan
- **Good frame.** Send a frame for 0x1C (start 0, data LSB-first, parity 0, stop 1), then read offset 0. Expect `dataOut`=0x0000011C and `irq` falling to 0 after the read.
- **Parity error.** Send 0x1C with parity=1, then read status. Expect `empty`=1 and `frame_err`=1 (`dataOut`=0x5). A second status read returns 0x1.
- **Overflow.** Send 9 frames 0x01..0x09 with no reads, then read status. Expect `count`=8, `full`=1 and `overflow`=1 (0x0000008A). Eight data reads then return 0x101..0x108, and the 9th read returns 0.
- **Same-cycle push/pop.** With the FIFO full of 8 entries, assert `rEn` to offset 0 in the same cycle the stop bit of 0x55 is sampled. Expect `overflow`=0, `count` still 8, and 0x55 as the last entry popped.
- **Timeout (with `PS2_RX_TIMEOUT_EN`).** Send a start bit and 4 data bits, then stop clocking. After `TIMEOUT_CYCLES`, expect `frame_err`=1. A following full frame 0xF0 then reads back as 0x1F0.
- **Reset mid-frame.** Assert `reset` for 1 cycle after 5 bits. All outputs read 0. A next full frame 0x2A reads back as 0x12A.
